// File: rtl/disp_arbiter.sv
// disp_arbiter: round-robin arbiter that gives one of four requesters the
// 4-digit LED display for a minimum dwell of DWELL cycles per grant.
// An idle display shows dashes. Define DISP_ARBITER_BLINK_EN to build in
// per-requester blinking with a half-period of BLINK_HALF cycles.
module disp_arbiter #(
  parameter int unsigned DWELL      = 100000000,
  parameter int unsigned BLINK_HALF = 25000000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [3:0]  req,
  input  logic [31:0] data0,
  input  logic [31:0] data1,
  input  logic [31:0] data2,
  input  logic [31:0] data3,
  input  logic [3:0]  blink,
  output logic [7:0]  seg0,
  output logic [7:0]  seg1,
  output logic [7:0]  seg2,
  output logic [7:0]  seg3,
  output logic [3:0]  gnt,
  output logic        busy
);

  localparam int unsigned CW     = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [31:0] DASHES = {4{8'h40}};

  typedef enum logic {IDLE, SHOW} state_t;

  state_t          state;
  logic [CW-1:0]   dwell;
  logic [1:0]      last;
  logic [31:0]     seg_q;
  logic [1:0]      win;
  logic            any;
  logic            expire;
  logic            do_grant;
  logic            go_idle;
  logic [31:0]     wdata;
  logic [31:0]     gdata;

  assign seg0 = seg_q[7:0];
  assign seg1 = seg_q[15:8];
  assign seg2 = seg_q[23:16];
  assign seg3 = seg_q[31:24];

  // Round-robin winner: first requester found searching upward from last+1.
  always_comb begin
    logic       found;
    logic [1:0] idx;
    win   = last;
    found = 1'b0;
    for (int unsigned i = 1; i <= 4; i++) begin
      idx = last + 2'(i);
      if (!found && req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  // Data of the round-robin winner and of the currently granted requester.
  always_comb begin
    case (win)
      2'd0:    wdata = data0;
      2'd1:    wdata = data1;
      2'd2:    wdata = data2;
      default: wdata = data3;
    endcase
    case (last)
      2'd0:    gdata = data0;
      2'd1:    gdata = data1;
      2'd2:    gdata = data2;
      default: gdata = data3;
    endcase
  end

  assign any      = |req;
  assign expire   = (state == SHOW) && (dwell == CW'(DWELL - 1));
  assign do_grant = any && ((state == IDLE) || expire);
  assign go_idle  = expire && !any;

`ifdef DISP_ARBITER_BLINK_EN
  localparam int unsigned BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

  logic [BW-1:0] bcnt;
  logic          blank;
  logic          blank_nx;
  logic [31:0]   held;
  logic [31:0]   word_nx;

  // Next blink phase and the word the granted requester would display.
  always_comb begin
    blank_nx = (bcnt == BW'(BLINK_HALF - 1)) ? ~blank : blank;
    word_nx  = req[last] ? gdata : held;
  end

  // Blink counter and the latched display word, restarted on every grant.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bcnt  <= '0;
      blank <= 1'b0;
      held  <= '0;
    end else if (do_grant) begin
      bcnt  <= '0;
      blank <= 1'b0;
      held  <= wdata;
    end else if (state == SHOW && !go_idle) begin
      bcnt  <= (bcnt == BW'(BLINK_HALF - 1)) ? '0 : bcnt + 1'b1;
      blank <= blank_nx;
      held  <= word_nx;
    end
  end
`else
  logic unused_blink;
  assign unused_blink = ^blink;
`endif

  // Arbitration FSM with registered grant, busy and segment outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      seg_q <= DASHES;
      gnt   <= '0;
      busy  <= 1'b0;
      dwell <= '0;
      last  <= 2'd3;
    end else if (do_grant) begin
      state <= SHOW;
      busy  <= 1'b1;
      gnt   <= 4'b0001 << win;
      last  <= win;
      dwell <= '0;
      seg_q <= wdata;
    end else if (go_idle) begin
      state <= IDLE;
      busy  <= 1'b0;
      gnt   <= '0;
      dwell <= '0;
      seg_q <= DASHES;
    end else if (state == SHOW) begin
      dwell <= dwell + 1'b1;
`ifdef DISP_ARBITER_BLINK_EN
      // Blanking is applied on top of the latched word so a held value
      // reappears intact in the next visible phase.
      seg_q <= (blink[last] && blank_nx) ? '0 : word_nx;
`else
      if (req[last]) seg_q <= gdata;
`endif
    end
  end

endmodule

// File: tb/tb_disp_arbiter.sv
// Scoreboard bench for disp_arbiter (DWELL=8, BLINK_HALF=2): a reference
// model predicts each registered output word at every rising edge, and a
// monitor compares the DUT outputs half a cycle later.
module tb_disp_arbiter;

  localparam int unsigned DW = 8;
  localparam int unsigned BH = 2;
`ifdef DISP_ARBITER_BLINK_EN
  localparam bit BLINK_ON = 1'b1;
`else
  localparam bit BLINK_ON = 1'b0;
`endif

  typedef struct packed {
    logic        busy;
    logic [3:0]  gnt;
    logic [31:0] seg;
  } obs_t;

  localparam obs_t RST_OBS = '{busy: 1'b0, gnt: 4'b0000, seg: 32'h40404040};

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [3:0]  req = '0;
  logic [3:0]  blink = '0;
  logic [31:0] d [4];
  logic [7:0]  seg0, seg1, seg2, seg3;
  logic [3:0]  gnt;
  logic        busy;

  int unsigned checks = 0;
  int unsigned errors = 0;
  obs_t        exp_q [$];

  // Reference model state: cur<0 means idle.
  int          cur = -1;
  int          age = 0;
  int          last = 3;
  logic [31:0] shown = '0;

  disp_arbiter #(.DWELL(DW), .BLINK_HALF(BH)) dut (
    .clk(clk), .reset_n(reset_n), .req(req),
    .data0(d[0]), .data1(d[1]), .data2(d[2]), .data3(d[3]),
    .blink(blink),
    .seg0(seg0), .seg1(seg1), .seg2(seg2), .seg3(seg3),
    .gnt(gnt), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic int rr_pick(logic [3:0] r);
    for (int i = 1; i <= 4; i++) begin
      if (r[(last + i) % 4]) return (last + i) % 4;
    end
    return last;
  endfunction

  function automatic obs_t predict();
    obs_t o;
    if (cur < 0) return RST_OBS;
    o.busy = 1'b1;
    o.gnt  = 4'b0001 << cur;
    if (BLINK_ON && blink[cur] && ((age / BH) % 2 == 1)) o.seg = '0;
    else o.seg = shown;
    return o;
  endfunction

  task automatic grant(int w);
    cur   = w;
    last  = w;
    age   = 0;
    shown = d[w];
  endtask

  // Asynchronous reset replaces any pending expectation.
  always @(negedge reset_n) begin
    cur  = -1;
    age  = 0;
    last = 3;
    exp_q.delete();
    exp_q.push_back(RST_OBS);
  end

  // Model step at each rising edge.
  always @(posedge clk) begin
    if (!reset_n) begin
      if (exp_q.size() == 0) exp_q.push_back(RST_OBS);
    end else begin
      if (cur < 0) begin
        if (req != 0) grant(rr_pick(req));
      end else if (age + 1 == DW) begin
        if (req == 0) cur = -1;
        else grant(rr_pick(req));
      end else begin
        age++;
        if (req[cur]) shown = d[cur];
      end
      exp_q.push_back(predict());
    end
  end

  // Monitor: compare on each falling edge.
  initial begin
    obs_t e, g;
    @(posedge clk);
    forever begin
      @(negedge clk);
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL underflow t=%0t: no expected entry", $time);
      end else begin
        e = exp_q.pop_front();
        g = '{busy: busy, gnt: gnt, seg: {seg3, seg2, seg1, seg0}};
        if (g !== e)
          $display("FAIL outputs t=%0t: got busy=%b gnt=%b seg=%h, expected busy=%b gnt=%b seg=%h",
                   $time, g.busy, g.gnt, g.seg, e.busy, e.gnt, e.seg);
        if (g !== e) errors++;
      end
    end
  end

  task automatic tick(int n);
    repeat (n) begin
      @(posedge clk);
      #3;
    end
  endtask

  task automatic rand_data();
    for (int i = 0; i < 4; i++) d[i] = $urandom;
  endtask

  initial begin
    rand_data();
    reset_n = 1'b0;
    tick(3);
    reset_n = 1'b1;
    tick(10);                              // idle after release: dashes

    d[0] = 32'h065B4F66; req = 4'b0001;    // single requester held
    tick(20);
    req = 4'b0000;
    tick(10);

    req = 4'b1111;                         // full rotation, data tracking
    repeat (45) begin
      tick(1);
      rand_data();
    end
    req = 4'b0000;
    tick(12);

    d[0] = 32'h11223344; req = 4'b0001;    // one-cycle pulse, then data changes
    tick(1);
    req = 4'b0000; d[0] = 32'hAABBCCDD;
    tick(12);

    req = 4'b0001;                         // late requester does not preempt
    tick(3);
    req = 4'b0101;
    tick(12);
    req = 4'b0000;
    tick(10);

    blink = 4'b0001; req = 4'b0001;        // blinking, then reset mid-blink
    tick(11);
    reset_n = 1'b0;
    tick(2);
    reset_n = 1'b1;
    tick(4);

    repeat (1500) begin                    // randomized traffic
      if ($urandom_range(0, 7) == 0) req = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 39) == 0) blink = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 0) d[$urandom_range(0, 3)] = $urandom;
      if ($urandom_range(0, 299) == 0) begin
        reset_n = 1'b0;
        tick($urandom_range(1, 2));
        reset_n = 1'b1;
      end
      tick(1);
    end

    req = 4'b0000;
    tick(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/disp_arbiter.md
DISP_ARBITER -- requirements
Module: disp_arbiter

Interface
REQ-001 Parameter: DWELL, default 100000000, minimum display time per grant in clk cycles (must be >= 2).
REQ-002 Parameter: BLINK_HALF, default 25000000, blink half-period in clk cycles (must be >= 1).
REQ-003 Port: clk  input  1  system clock, 100 MHz, rising-edge.
REQ-004 Port: reset_n  input  1  asynchronous, active-low reset.
REQ-005 Port: req  input  4  per-requester display request, level-held.
REQ-006 Port: data0..data3  input  32 each  pre-formatted segment bytes {DP,G:A}, active-high; [7:0]=digit0 ... [31:24]=digit3.
REQ-007 Port: blink  input  4  per-requester blink enable; used only under the configuration macro.
REQ-008 Port: seg0..seg3  output  8 each  registered digit bytes for the 4-digit LED driver.
REQ-009 Port: gnt  output  4  one-hot grant, registered; all-zero when idle.
REQ-010 Port: busy  output  1  high in SHOW state.

Function
REQ-011 The block SHALL have two states: IDLE and SHOW.
REQ-012 In IDLE, seg0..seg3 SHALL equal 8'h40 (dash), gnt SHALL be 0, and busy SHALL be 0.
REQ-013 In IDLE with req != 0 at edge t, the block SHALL enter SHOW at edge t, assert the round-robin winner in gnt, and load segN from the winner's data on that same edge (1-cycle latency).
REQ-014 Round-robin order SHALL search from (last_granted+1) mod 4 upward; last_granted resets to 3, so requester 0 has first priority.
REQ-015 On every grant, a dwell counter SHALL load 0 and increment each cycle in SHOW; expiry is the cycle the count equals DWELL-1.
REQ-016 While in SHOW with req[g] high, segN SHALL track the granted requester's data every cycle.
REQ-017 While in SHOW with req[g] low, segN SHALL hold the last displayed value; the grant is not released before expiry.
REQ-018 At expiry, if any other requester is requesting, the block SHALL grant the next round-robin winner on the same edge, reload the data, and restart the dwell counter.
REQ-019 At expiry, if only the current requester is requesting, the block SHALL keep the grant and restart the dwell counter.
REQ-020 At expiry, if no requester is requesting, the block SHALL return to IDLE.
REQ-021 A new request arriving mid-dwell SHALL NOT preempt the current grant.
REQ-022 gnt SHALL always be one-hot or zero; last_granted SHALL update only on a grant edge.
REQ-023 The dwell counter width SHALL be clog2(DWELL), and the counter SHALL never wrap within a dwell.

Reset
REQ-024 While reset_n is low, asynchronously: state=IDLE, segN=8'h40, gnt=0, busy=0, dwell and blink counters=0, last_granted=3, blink phase=visible.
REQ-025 Reset asserted mid-SHOW SHALL abandon the grant immediately, with no residual data on segN.
REQ-026 After release, the first grant SHALL occur no earlier than the first rising edge with reset_n high.

Configuration
REQ-027 Macro DISP_ARBITER_BLINK_EN, when defined: with blink[g] high in SHOW, segN SHALL alternate between the granted data and 8'h00 every BLINK_HALF cycles, starting visible at each grant.
REQ-028 The blink counter SHALL reset on every grant.
REQ-029 With blink[g] low, the display SHALL be steady.
REQ-030 When DISP_ARBITER_BLINK_EN is not defined: the blink input SHALL be ignored, no blink counter SHALL be synthesized, and the display SHALL always be steady.

Verification (DWELL=8, BLINK_HALF=2)
REQ-031 Scenario: reset_n low, then released, no req -> seg0..3=8'h40, gnt=0, busy=0 indefinitely.
REQ-032 Scenario: req=0001, data0=32'h06_5B_4F_66 -> next edge gnt=0001, seg0=8'h66, seg3=8'h06; gnt held while req holds.
REQ-033 Scenario: req=1111 held -> grants cycle 0001, 0010, 0100, 1000, 0001, each lasting exactly 8 cycles.
REQ-034 Scenario: req0 pulsed 1 cycle, data0 then changed -> gnt=0001 for 8 cycles showing the pulse-cycle data, then IDLE with dashes.
REQ-035 Scenario: req2 raised 3 cycles into a req0 grant -> req0 keeps its grant until cycle 8, and gnt=0100 on the next edge.
REQ-036 Scenario: BLINK_EN defined, blink0=1, req0 held -> seg0 pattern is data for 2 cycles, 8'h00 for 2 cycles, repeating; reset_n low mid-blink -> dashes immediately.
